iopmp_err_arbiter: RTL and testbench
====================================

IOPMP_ERR_ARBITER -- requirements
Module: iopmp_err_arbiter

Interface
REQ-001 SHALL have parameter IOPMPNumChan, default 4, meaning the number of checker channels reporting errors (2..16).
REQ-002 SHALL have parameter RridWidth, default 8, meaning the width of the requester ID.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, the reset: asynchronous and active-low.
REQ-005 SHALL have per-channel inputs err_valid_i[IOPMPNumChan] (1, violation pending), err_addr_i (34, request address), err_rrid_i (RridWidth), err_eid_i (8, violated entry index), err_ttype_i (2, transaction type) and err_etype_i (3, error type).
REQ-006 SHALL have output err_ack_o[IOPMPNumChan], 1 each: a combinational acknowledge; a channel holds valid and payload stable until it sees ack.
REQ-007 SHALL have input rec_clear_i, 1: a software write-1-to-clear of the error record.
REQ-008 SHALL have input irq_en_i, 1: the interrupt enable.
REQ-009 SHALL have record outputs rec_valid_o (1), rec_addr_o (34), rec_rrid_o, rec_eid_o (8), rec_ttype_o (2), rec_etype_o (3), rec_chan_o ($clog2(IOPMPNumChan)) and drop_cnt_o (8).
REQ-010 SHALL have output irq_o, 1, equal to rec_valid_o AND irq_en_i (combinational).
REQ-011 SHALL have output svc_o[IOPMPNumChan], 1 each: the subsequent-violation flags (see Configuration).

Function
REQ-012 SHALL implement a two-state FSM: IDLE (no record held) and LOCKED (record held); rec_valid_o is 1 exactly in LOCKED.
REQ-013 In IDLE with at least one valid, SHALL grant one channel by round-robin, starting the search at rr_ptr.
REQ-014 In IDLE, SHALL assert err_ack_o only for the granted channel, in the same cycle.
REQ-015 On the granting edge, SHALL register the granted payload and channel index into the record, go to LOCKED, and set rr_ptr to (grant+1) mod IOPMPNumChan.
REQ-016 Record outputs SHALL therefore be visible one cycle after the ack (capture latency 1).
REQ-017 In LOCKED, SHALL acknowledge every valid channel in the same cycle (the requests are dropped) and hold the record unchanged.
REQ-018 In LOCKED, drop_cnt_o SHALL increase by popcount(valid) each cycle and saturate at 255.
REQ-019 When rec_clear_i is 1 in LOCKED, SHALL go to IDLE next cycle and clear drop_cnt_o to 0.
REQ-020 When rec_clear_i and valids occur in the same cycle in LOCKED, the clear SHALL win and those valids SHALL still be acked and dropped; they SHALL NOT be captured.
REQ-021 rec_clear_i in IDLE SHALL have no effect, including when valid is present.
REQ-022 The record fields SHALL keep their last values after a clear; only rec_valid_o falls.
REQ-023 Round-robin fairness: a channel continuously valid SHALL be granted within IOPMPNumChan captures.

Reset
REQ-024 While rst=0, SHALL go to IDLE with rr_ptr=0, every record field 0, drop_cnt_o=0, svc_o all 0, and hence rec_valid_o=0 and irq_o=0.
REQ-025 Reset asserted mid-LOCKED SHALL discard the record immediately (asynchronously).
REQ-026 err_ack_o SHALL be 0 while rst=0.

Configuration
REQ-027 The feature is controlled by macro IOPMP_ERR_SVC_EN.
REQ-028 When IOPMP_ERR_SVC_EN is defined, in LOCKED svc_o[j] SHALL be set for each dropped channel j.
REQ-029 When IOPMP_ERR_SVC_EN is defined, svc_o SHALL be cleared together with the record on rec_clear_i.
REQ-030 Without IOPMP_ERR_SVC_EN, svc_o SHALL be constant 0 and no flag registers SHALL exist.

Verification
REQ-031 Single error: ch2 valid with addr 0x0_1000_0040, eid 5, rrid 3 -> same-cycle ack[2] only; next cycle rec_valid=1, rec_chan=2, fields match; with irq_en=1, irq_o=1.
REQ-032 Simultaneous valids: ch0 and ch3 valid, rr_ptr=0 -> ch0 captured, ack[0]=1 and ack[3]=0; then in LOCKED ch3 is acked and dropped, drop_cnt=1; svc_o[3]=1 only if macro defined.
REQ-033 Round-robin: all 4 channels continuously valid, clear every other cycle -> captures in order ch0, ch1, ch2, ch3, ch0.
REQ-034 Saturation: hold 4 valids in LOCKED for 70 cycles -> drop_cnt=255 and stays 255; clear -> 0.
REQ-035 Clear race and reset: clear together with a ch1 valid -> ack[1]=1, next cycle IDLE with rec_valid=0; then rst=0 mid-LOCKED -> rec_valid=0 and all outputs 0 without waiting for a clock edge.

Source files
------------

// File: rtl/iopmp_err_arbiter_if.sv
// Error-report channel bundle between the IOPMP checker channels and iopmp_err_arbiter.
// The checker side drives valid and payload; the arbiter side returns one ack per channel.
interface iopmp_err_arbiter_if #(
    parameter int unsigned IOPMPNumChan = 4,
    parameter int unsigned RridWidth    = 8
);
    logic [IOPMPNumChan-1:0] err_valid_i;
    logic [33:0]             err_addr_i  [IOPMPNumChan];
    logic [RridWidth-1:0]    err_rrid_i  [IOPMPNumChan];
    logic [7:0]              err_eid_i   [IOPMPNumChan];
    logic [1:0]              err_ttype_i [IOPMPNumChan];
    logic [2:0]              err_etype_i [IOPMPNumChan];
    logic [IOPMPNumChan-1:0] err_ack_o;

    modport master (
        output err_valid_i,
        output err_addr_i,
        output err_rrid_i,
        output err_eid_i,
        output err_ttype_i,
        output err_etype_i,
        input  err_ack_o
    );

    modport slave (
        input  err_valid_i,
        input  err_addr_i,
        input  err_rrid_i,
        input  err_eid_i,
        input  err_ttype_i,
        input  err_etype_i,
        output err_ack_o
    );
endinterface

// File: rtl/iopmp_err_arbiter.sv
// Round-robin capture of one IOPMP violation record; later violations are acked and counted as drops.
// Optional per-channel subsequent-violation flags are built when IOPMP_ERR_SVC_EN is defined.
module iopmp_err_arbiter #(
    parameter int unsigned IOPMPNumChan = 4,
    parameter int unsigned RridWidth    = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    iopmp_err_arbiter_if.slave              chan,
    input  logic                            rec_clear_i,
    input  logic                            irq_en_i,
    output logic                            rec_valid_o,
    output logic [33:0]                     rec_addr_o,
    output logic [RridWidth-1:0]            rec_rrid_o,
    output logic [7:0]                      rec_eid_o,
    output logic [1:0]                      rec_ttype_o,
    output logic [2:0]                      rec_etype_o,
    output logic [$clog2(IOPMPNumChan)-1:0] rec_chan_o,
    output logic [7:0]                      drop_cnt_o,
    output logic                            irq_o,
    output logic [IOPMPNumChan-1:0]         svc_o
);
    localparam int unsigned ChanW = $clog2(IOPMPNumChan);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    logic [0:0]             r_state;
    logic [ChanW-1:0]       r_rr_ptr;
    logic [33:0]            r_rec_addr;
    logic [RridWidth-1:0]   r_rec_rrid;
    logic [7:0]             r_rec_eid;
    logic [1:0]             r_rec_ttype;
    logic [2:0]             r_rec_etype;
    logic [ChanW-1:0]       r_rec_chan;
    logic [7:0]             r_drop_cnt;

    logic                    w_locked;
    logic                    w_gnt_found;
    logic [ChanW-1:0]        w_gnt_idx;
    logic [IOPMPNumChan-1:0] w_gnt_oh;
    logic [4:0]              w_pop;
    logic [8:0]              w_drop_sum;
    logic [7:0]              w_drop_next;
    logic [ChanW-1:0]        w_rr_next;

    assign w_locked = (r_state == ST_LOCKED);

    // First valid channel at or after r_rr_ptr, wrapping modulo IOPMPNumChan.
    always_comb begin
        logic [ChanW:0]   v_sum;
        logic [ChanW-1:0] v_idx;
        w_gnt_found = 1'b0;
        w_gnt_idx   = '0;
        v_sum       = '0;
        v_idx       = '0;
        for (int unsigned k = 0; k < IOPMPNumChan; k++) begin
            v_sum = {1'b0, r_rr_ptr} + (ChanW+1)'(k);
            if (v_sum >= (ChanW+1)'(IOPMPNumChan)) begin
                v_sum = v_sum - (ChanW+1)'(IOPMPNumChan);
            end
            v_idx = v_sum[ChanW-1:0];
            if (!w_gnt_found && chan.err_valid_i[v_idx]) begin
                w_gnt_found = 1'b1;
                w_gnt_idx   = v_idx;
            end
        end
    end

    always_comb begin
        w_gnt_oh = '0;
        if (w_gnt_found) begin
            w_gnt_oh[w_gnt_idx] = 1'b1;
        end
    end

    assign w_rr_next = (w_gnt_idx == ChanW'(IOPMPNumChan - 1)) ? '0 : w_gnt_idx + ChanW'(1);

    // While locked every pending channel is released at once, so it never stalls behind the record.
    always_comb begin
        if (!rst) begin
            chan.err_ack_o = '0;
        end else if (w_locked) begin
            chan.err_ack_o = chan.err_valid_i;
        end else begin
            chan.err_ack_o = w_gnt_oh;
        end
    end

    assign w_pop       = 5'($countones(chan.err_valid_i));
    assign w_drop_sum  = {1'b0, r_drop_cnt} + 9'(w_pop);
    assign w_drop_next = w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_rr_ptr    <= '0;
            r_rec_addr  <= '0;
            r_rec_rrid  <= '0;
            r_rec_eid   <= '0;
            r_rec_ttype <= '0;
            r_rec_etype <= '0;
            r_rec_chan  <= '0;
            r_drop_cnt  <= '0;
        end else if (r_state == ST_IDLE) begin
            if (w_gnt_found) begin
                r_state     <= ST_LOCKED;
                r_rr_ptr    <= w_rr_next;
                r_rec_addr  <= chan.err_addr_i[w_gnt_idx];
                r_rec_rrid  <= chan.err_rrid_i[w_gnt_idx];
                r_rec_eid   <= chan.err_eid_i[w_gnt_idx];
                r_rec_ttype <= chan.err_ttype_i[w_gnt_idx];
                r_rec_etype <= chan.err_etype_i[w_gnt_idx];
                r_rec_chan  <= w_gnt_idx;
            end
        end else begin
            // Clear takes priority over same-cycle drops; record fields are deliberately kept.
            if (rec_clear_i) begin
                r_state    <= ST_IDLE;
                r_drop_cnt <= '0;
            end else begin
                r_drop_cnt <= w_drop_next;
            end
        end
    end

`ifdef IOPMP_ERR_SVC_EN
    logic [IOPMPNumChan-1:0] r_svc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_svc <= '0;
        end else if (w_locked) begin
            if (rec_clear_i) begin
                r_svc <= '0;
            end else begin
                r_svc <= r_svc | chan.err_valid_i;
            end
        end
    end

    assign svc_o = r_svc;
`else
    assign svc_o = '0;
`endif

    assign rec_valid_o = w_locked;
    assign rec_addr_o  = r_rec_addr;
    assign rec_rrid_o  = r_rec_rrid;
    assign rec_eid_o   = r_rec_eid;
    assign rec_ttype_o = r_rec_ttype;
    assign rec_etype_o = r_rec_etype;
    assign rec_chan_o  = r_rec_chan;
    assign drop_cnt_o  = r_drop_cnt;
    assign irq_o       = w_locked & irq_en_i;

endmodule

// File: tb/tb_iopmp_err_arbiter.sv
// Directed self-checking bench for iopmp_err_arbiter (4 channels, 8-bit RRID).
// svc_o expectations follow IOPMP_ERR_SVC_EN when the bench is built with the same macro.
module tb_iopmp_err_arbiter;
    logic       clk;
    logic       rst;
    logic       rec_clear;
    logic       irq_en;
    logic       rec_valid;
    logic [33:0] rec_addr;
    logic [7:0] rec_rrid;
    logic [7:0] rec_eid;
    logic [1:0] rec_ttype;
    logic [2:0] rec_etype;
    logic [1:0] rec_chan;
    logic [7:0] drop_cnt;
    logic       irq;
    logic [3:0] svc;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    iopmp_err_arbiter_if #(.IOPMPNumChan(4), .RridWidth(8)) bus ();

    iopmp_err_arbiter #(.IOPMPNumChan(4), .RridWidth(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .chan        (bus),
        .rec_clear_i (rec_clear),
        .irq_en_i    (irq_en),
        .rec_valid_o (rec_valid),
        .rec_addr_o  (rec_addr),
        .rec_rrid_o  (rec_rrid),
        .rec_eid_o   (rec_eid),
        .rec_ttype_o (rec_ttype),
        .rec_etype_o (rec_etype),
        .rec_chan_o  (rec_chan),
        .drop_cnt_o  (drop_cnt),
        .irq_o       (irq),
        .svc_o       (svc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_payload(input int ch, input logic [33:0] a, input logic [7:0] rr,
                               input logic [7:0] e, input logic [1:0] tt, input logic [2:0] et);
        bus.err_addr_i[ch]  = a;
        bus.err_rrid_i[ch]  = rr;
        bus.err_eid_i[ch]   = e;
        bus.err_ttype_i[ch] = tt;
        bus.err_etype_i[ch] = et;
    endtask

    logic [3:0] exp_svc;

    initial begin
        rst       = 1'b0;
        rec_clear = 1'b0;
        irq_en    = 1'b1;
        bus.err_valid_i = 4'b0001;
        for (int i = 0; i < 4; i++) set_payload(i, '0, '0, '0, '0, '0);

        // Reset state, including ack suppressed while a valid is present.
        #12;
        chk("rst_rec_valid", 64'(rec_valid), 64'd0);
        chk("rst_irq", 64'(irq), 64'd0);
        chk("rst_drop", 64'(drop_cnt), 64'd0);
        chk("rst_ack", 64'(bus.err_ack_o), 64'd0);
        chk("rst_svc", 64'(svc), 64'd0);
        bus.err_valid_i = 4'b0000;
        tick();
        rst = 1'b1;

        // Single error on ch2.
        set_payload(2, 34'h0_1000_0040, 8'd3, 8'd5, 2'b10, 3'b101);
        bus.err_valid_i = 4'b0100;
        #1;
        chk("t1_ack", 64'(bus.err_ack_o), 64'h4);
        chk("t1_valid_before", 64'(rec_valid), 64'd0);
        tick();
        bus.err_valid_i = 4'b0000;
        chk("t1_rec_valid", 64'(rec_valid), 64'd1);
        chk("t1_chan", 64'(rec_chan), 64'd2);
        chk("t1_addr", 64'(rec_addr), 64'h0_1000_0040);
        chk("t1_eid", 64'(rec_eid), 64'd5);
        chk("t1_rrid", 64'(rec_rrid), 64'd3);
        chk("t1_ttype", 64'(rec_ttype), 64'h2);
        chk("t1_etype", 64'(rec_etype), 64'h5);
        chk("t1_irq", 64'(irq), 64'd1);
        irq_en = 1'b0;
        #1;
        chk("t1_irq_masked", 64'(irq), 64'd0);
        irq_en = 1'b1;
        rec_clear = 1'b1;
        tick();
        rec_clear = 1'b0;
        chk("t1_cleared", 64'(rec_valid), 64'd0);
        chk("t1_addr_kept", 64'(rec_addr), 64'h0_1000_0040);
        chk("t1_irq_cleared", 64'(irq), 64'd0);

        // Reset clears record fields and rr_ptr.
        rst = 1'b0;
        #1;
        chk("rst2_addr", 64'(rec_addr), 64'd0);
        chk("rst2_chan", 64'(rec_chan), 64'd0);
        rst = 1'b1;
        #1;

        // Simultaneous valids on ch0 and ch3 with rr_ptr=0.
        set_payload(0, 34'h2_0000_0A00, 8'hA0, 8'd10, 2'b01, 3'b001);
        set_payload(3, 34'h3_FFFF_FFF0, 8'hA3, 8'd13, 2'b11, 3'b011);
        bus.err_valid_i = 4'b1001;
        #1;
        chk("t2_ack_idle", 64'(bus.err_ack_o), 64'h1);
        tick();
        bus.err_valid_i = 4'b1000;
        #1;
        chk("t2_chan", 64'(rec_chan), 64'd0);
        chk("t2_addr", 64'(rec_addr), 64'h2_0000_0A00);
        chk("t2_ack_locked", 64'(bus.err_ack_o), 64'h8);
        tick();
        bus.err_valid_i = 4'b0000;
        chk("t2_drop", 64'(drop_cnt), 64'd1);
`ifdef IOPMP_ERR_SVC_EN
        exp_svc = 4'b1000;
`else
        exp_svc = 4'b0000;
`endif
        chk("t2_svc", 64'(svc), 64'(exp_svc));
        chk("t2_rec_kept", 64'(rec_addr), 64'h2_0000_0A00);
        rec_clear = 1'b1;
        tick();
        rec_clear = 1'b0;
        chk("t2_drop_clr", 64'(drop_cnt), 64'd0);
        chk("t2_svc_clr", 64'(svc), 64'd0);

        // Round-robin from rr_ptr=0 with all channels valid, clear every other cycle.
        rst = 1'b0;
        #1;
        rst = 1'b1;
        bus.err_valid_i = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            #1;
            chk($sformatf("t3_ack%0d", n), 64'(bus.err_ack_o), 64'(4'b0001 << (n % 4)));
            tick();
            chk($sformatf("t3_chan%0d", n), 64'(rec_chan), 64'(n % 4));
            chk($sformatf("t3_valid%0d", n), 64'(rec_valid), 64'd1);
            rec_clear = 1'b1;
            tick();
            rec_clear = 1'b0;
            chk($sformatf("t3_clr%0d", n), 64'(rec_valid), 64'd0);
        end

        // Saturation: rr_ptr is now 1, all four still valid.
        #1;
        chk("t4_ack_idle", 64'(bus.err_ack_o), 64'h2);
        tick();
        chk("t4_chan", 64'(rec_chan), 64'd1);
        for (int k = 1; k <= 70; k++) begin
            tick();
            if (k == 1)  chk("t4_drop1", 64'(drop_cnt), 64'd4);
            if (k == 63) chk("t4_drop63", 64'(drop_cnt), 64'd252);
            if (k == 64) chk("t4_drop64", 64'(drop_cnt), 64'd255);
            if (k == 70) chk("t4_drop70", 64'(drop_cnt), 64'd255);
        end
`ifdef IOPMP_ERR_SVC_EN
        exp_svc = 4'b1111;
`else
        exp_svc = 4'b0000;
`endif
        chk("t4_svc", 64'(svc), 64'(exp_svc));
        rec_clear = 1'b1;
        tick();
        rec_clear = 1'b0;
        bus.err_valid_i = 4'b0000;
        chk("t4_drop_clr", 64'(drop_cnt), 64'd0);
        chk("t4_unlocked", 64'(rec_valid), 64'd0);

        // Clear in IDLE is ignored; rr_ptr=2 so ch0 is found after wrapping.
        set_payload(0, 34'h0_0000_1234, 8'h11, 8'd1, 2'b00, 3'b010);
        bus.err_valid_i = 4'b0001;
        rec_clear = 1'b1;
        #1;
        chk("t5_ack_wrap", 64'(bus.err_ack_o), 64'h1);
        tick();
        chk("t5_idle_clr_ignored", 64'(rec_valid), 64'd1);
        chk("t5_chan", 64'(rec_chan), 64'd0);

        // Clear racing a ch1 valid: ch1 is acked and dropped, not captured.
        set_payload(1, 34'h1_5555_0000, 8'h22, 8'd2, 2'b01, 3'b100);
        bus.err_valid_i = 4'b0010;
        #1;
        chk("t5_race_ack", 64'(bus.err_ack_o), 64'h2);
        tick();
        bus.err_valid_i = 4'b0000;
        rec_clear = 1'b0;
        chk("t5_race_idle", 64'(rec_valid), 64'd0);
        chk("t5_race_chan", 64'(rec_chan), 64'd0);
        chk("t5_race_addr", 64'(rec_addr), 64'h0_0000_1234);
        chk("t5_race_drop", 64'(drop_cnt), 64'd0);

        // Asynchronous reset while locked with a nonzero drop count.
        set_payload(2, 34'h0_ABCD_0000, 8'h33, 8'd7, 2'b11, 3'b111);
        bus.err_valid_i = 4'b0100;
        tick();
        bus.err_valid_i = 4'b1000;
        chk("t6_locked", 64'(rec_chan), 64'd2);
        tick();
        bus.err_valid_i = 4'b0001;
        chk("t6_drop", 64'(drop_cnt), 64'd1);
        #3;
        rst = 1'b0;
        #1;
        chk("t6_rec_valid", 64'(rec_valid), 64'd0);
        chk("t6_irq", 64'(irq), 64'd0);
        chk("t6_addr", 64'(rec_addr), 64'd0);
        chk("t6_chan", 64'(rec_chan), 64'd0);
        chk("t6_drop0", 64'(drop_cnt), 64'd0);
        chk("t6_ack", 64'(bus.err_ack_o), 64'd0);
        chk("t6_svc", 64'(svc), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
